ball_dir_ctrl: RTL
==================

// Module: ball_dir_ctrl
// PURPOSE
//  Direction and step controller directly upstream of the ball position counters.
//  Paces ball motion with a tick divider and resolves wall, paddle and brick bounces.
//  Drives the position stage's enable, x_du and y_du (1 = coordinate increments),
//  and the plat_col pulse. Reads back the current integer ball x/y.
// PARAMETERS
//  SCREEN_W   160     playfield width in pixels
//  SCREEN_H   120     playfield height in pixels
//  BALL_SIZE  2       ball edge length in pixels
//  PLAT_Y     110     top row of the paddle
//  PLAT_SIZE  20      paddle width in pixels
//  TICK_DIV   833333  clk cycles per ball step (60 Hz at 50 MHz); 20-bit max
//  TICK_STEP  41667   period reduction per paddle hit (BALL_SPEEDUP_EN only)
//  TICK_MIN   416667  period floor (BALL_SPEEDUP_EN only)
// PORTS
//  clk          in   1   clock
//  resetn       in   1   synchronous, active-low reset
//  go           in   1   serve request; level or pulse, sampled in IDLE
//  x            in   10  current ball x (integer part)
//  y            in   10  current ball y (integer part)
//  platx        in   10  paddle left edge
//  brick_hit_x  in   1   one-cycle pulse: brick contact on a vertical face
//  brick_hit_y  in   1   one-cycle pulse: brick contact on a horizontal face
//  enable       out  1   one-cycle step strobe to the position counters
//  x_du         out  1   x direction, 1 = +x
//  y_du         out  1   y direction, 1 = +y (down)
//  plat_col     out  1   one-cycle pulse on a paddle bounce
//  ball_lost    out  1   high while in LOST
// BEHAVIOUR
//  Reset values: state IDLE, x_du=1, y_du=0, enable=0, plat_col=0, ball_lost=0,
//   tick count 0, period TICK_DIV, brick flags cleared.
//  IDLE: outputs hold. go=1 moves to RUN with the tick count cleared.
//  RUN: the tick count increments. At count TICK_DIV-1 it wraps to 0 and the FSM moves to CHECK.
//  CHECK (1 cycle): x_du/y_du are updated from the x,y sampled this cycle; next state is STEP.
//   - x axis:
//       - x_du=1 and x >= SCREEN_W-BALL_SIZE -> x_du=0
//       - x_du=0 and x == 0 -> x_du=1
//       - otherwise the latched brick_x flag toggles x_du.
//   - y axis:
//       - y_du=0 and y == 0 -> y_du=1
//       - y_du=1, y+BALL_SIZE == PLAT_Y, x+BALL_SIZE > platx and x < platx+PLAT_SIZE
//         -> y_du=0 and plat_col=1 for this cycle
//       - y_du=1 and y >= SCREEN_H-BALL_SIZE -> next state is LOST instead of STEP
//       - otherwise the latched brick_y flag toggles y_du.
//   - Wall and paddle rules force a direction and override a pending brick toggle on the same axis.
//   - Both axes are evaluated independently; a corner hit flips both.
//   - Both brick flags clear on exit from CHECK.
//  STEP (1 cycle): enable=1, then RUN. Directions are stable one cycle before enable.
//   Latency from tick wrap to enable is 2 cycles.
//  LOST: enable=0, ball_lost=1. Exit only through resetn; the top level reasserts resetn to re-serve.
//  Brick flags are sticky, set by brick_hit_x/brick_hit_y pulses in any state except IDLE/LOST.
//   A pulse arriving in the CHECK cycle is kept for the next tick.
//  Arithmetic: comparisons are 11-bit unsigned to avoid wrap. The tick counter is 20 bits.
//  Reset mid-operation: the next edge restores every reset value, including an in-flight STEP.
// CONFIGURATION
//  BALL_SPEEDUP_EN defined:
//   - each plat_col subtracts TICK_STEP from the period, saturating at TICK_MIN;
//   - the new period takes effect from the next tick.
//  BALL_SPEEDUP_EN undefined: the period is fixed at TICK_DIV and no period register is built.
// STRUCTURE
//  macros.v (shared): screen bounds, PLATSIZE, PLATHALF, BALLX/BALLY, state encodings
//   IDLE=2'd0, RUN=2'd1, CHECK=2'd2, STEP=2'd3, plus a separate lost flag.
//  Sub-module ball_tick_gen: clear, period input, tick_out pulse on wrap.
//   The FSM clears it on entry to RUN.
// TESTING (bench: TICK_DIV=4, TICK_STEP=1, TICK_MIN=2, x/y driven by a ball_pos model)
//  1. Reset, go=1 -> first enable exactly 6 cycles after go sampled; x_du=1, y_du=0 at the strobe.
//  2. x=158, x_du=1 at CHECK -> x_du=0 before STEP; x=0, x_du=0 -> x_du=1.
//  3. y=108, platx=50, x=55, y_du=1 -> y_du=0 with one plat_col pulse;
//     same with x=80 -> no bounce.
//  4. brick_hit_x pulse mid-RUN -> x_du toggles at next CHECK only;
//     brick_hit_y together with y=0 -> y_du=1, not a toggle.
//  5. y=118, y_du=1, paddle away -> ball_lost=1, enable stays 0; resetn=0 one cycle -> IDLE reset values.
//  6. BALL_SPEEDUP_EN: three paddle hits -> enable spacing goes 6,5,4,4 cycles;
//     undefined -> spacing stays 6.

Source files
------------

// File: rtl/ball_dir_ctrl_pkg.sv
// Shared definitions for the ball direction controller.
//  - state_t      : controller FSM states (LOST is a separate flag, not a state)
//  - CMP_W        : width of the unsigned position comparisons
//  - TICK_W       : width of the tick counter and the step period
//  - sat_period() : shortens the step period, clamping at a floor
package ball_dir_ctrl_pkg;

    localparam int CMP_W  = 11;
    localparam int TICK_W = 20;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        CHECK = 2'd2,
        STEP  = 2'd3
    } state_t;

    // The compare is done one bit wider so that cur - step can never wrap
    // below zero before it is clamped to the floor.
    function automatic logic [TICK_W-1:0] sat_period(
        input logic [TICK_W-1:0] cur,
        input logic [TICK_W-1:0] step,
        input logic [TICK_W-1:0] floor_val
    );
        if ({1'b0, cur} < ({1'b0, floor_val} + {1'b0, step}))
            return floor_val;
        else
            return cur - step;
    endfunction

endpackage

// File: rtl/ball_tick_gen.sv
// Ball step pacing counter.
// Counts clock cycles while not cleared and pulses tick_out on the cycle
// where the count reaches period-1; the count wraps to 0 on that same edge.
// Ports:
//  clk      in   clock
//  resetn   in   synchronous, active-low reset
//  clear    in   holds the count at 0 (asserted whenever the FSM is not in RUN)
//  period   in   cycles per tick
//  tick_out out  combinational one-cycle pulse on the wrapping cycle
module ball_tick_gen
    import ball_dir_ctrl_pkg::*;
(
    input  logic              clk,
    input  logic              resetn,
    input  logic              clear,
    input  logic [TICK_W-1:0] period,
    output logic              tick_out
);

    logic [TICK_W-1:0] count;

    // tick_out is combinational so the FSM can leave RUN on the very edge
    // where the count wraps.
    assign tick_out = !clear && (count == (period - 1'b1));

    // Free-running counter, held at zero while cleared.
    always_ff @(posedge clk) begin
        if (!resetn)
            count <= '0;
        else if (clear)
            count <= '0;
        else if (tick_out)
            count <= '0;
        else
            count <= count + 1'b1;
    end

endmodule

// File: rtl/ball_dir_ctrl.sv
// Ball direction and step controller, sitting directly upstream of the
// ball position counters. Paces motion with ball_tick_gen and resolves
// wall, paddle and brick bounces once per tick.
// Optional feature macro: BALL_SPEEDUP_EN
//  When defined, each paddle bounce shortens the step period by TICK_STEP,
//  down to TICK_MIN. When undefined, the period is the constant TICK_DIV.
// Ports:
//  clk          in   clock
//  resetn       in   synchronous, active-low reset
//  go           in   serve request, sampled in IDLE
//  x, y         in   current ball position (integer part)
//  platx        in   paddle left edge
//  brick_hit_x  in   pulse: brick contact on a vertical face
//  brick_hit_y  in   pulse: brick contact on a horizontal face
//  enable       out  one-cycle step strobe to the position counters
//  x_du, y_du   out  direction, 1 = coordinate increments
//  plat_col     out  one-cycle pulse on a paddle bounce
//  ball_lost    out  high once the ball has dropped past the paddle
module ball_dir_ctrl
    import ball_dir_ctrl_pkg::*;
#(
    parameter int SCREEN_W  = 160,
    parameter int SCREEN_H  = 120,
    parameter int BALL_SIZE = 2,
    parameter int PLAT_Y    = 110,
    parameter int PLAT_SIZE = 20,
    parameter int TICK_DIV  = 833333,
    parameter int TICK_STEP = 41667,
    parameter int TICK_MIN  = 416667
)
(
    input  logic       clk,
    input  logic       resetn,
    input  logic       go,
    input  logic [9:0] x,
    input  logic [9:0] y,
    input  logic [9:0] platx,
    input  logic       brick_hit_x,
    input  logic       brick_hit_y,
    output logic       enable,
    output logic       x_du,
    output logic       y_du,
    output logic       plat_col,
    output logic       ball_lost
);

    localparam logic [CMP_W-1:0] X_MAX    = CMP_W'(SCREEN_W - BALL_SIZE);
    localparam logic [CMP_W-1:0] Y_MAX    = CMP_W'(SCREEN_H - BALL_SIZE);
    localparam logic [CMP_W-1:0] BALL_W   = CMP_W'(BALL_SIZE);
    localparam logic [CMP_W-1:0] PLAT_TOP = CMP_W'(PLAT_Y);
    localparam logic [CMP_W-1:0] PLAT_W   = CMP_W'(PLAT_SIZE);

    state_t            state;
    logic              brick_x;
    logic              brick_y;
    logic              tick;
    logic [TICK_W-1:0] period;
    logic              next_x_du;
    logic              next_y_du;
    logic              paddle_hit;
    logic              fall_out;
    logic [CMP_W-1:0]  x_w;
    logic [CMP_W-1:0]  y_w;
    logic [CMP_W-1:0]  platx_w;

    // Zero-extend so that x+BALL_SIZE and platx+PLAT_SIZE cannot wrap.
    assign x_w     = {1'b0, x};
    assign y_w     = {1'b0, y};
    assign platx_w = {1'b0, platx};

`ifdef BALL_SPEEDUP_EN
    // The counter is cleared outside RUN, so a shorter period only ever
    // applies from the start of the following tick.
    always_ff @(posedge clk) begin
        if (!resetn)
            period <= TICK_W'(TICK_DIV);
        else if (state == CHECK && paddle_hit)
            period <= sat_period(period, TICK_W'(TICK_STEP), TICK_W'(TICK_MIN));
    end
`else
    assign period = TICK_W'(TICK_DIV);
`endif

    ball_tick_gen u_tick (
        .clk      (clk),
        .resetn   (resetn),
        .clear    (state != RUN),
        .period   (period),
        .tick_out (tick)
    );

    // Bounce resolution for the CHECK cycle. Wall and paddle rules force a
    // direction and so take priority over a pending brick toggle; the two
    // axes are independent, so a corner flips both.
    always_comb begin
        paddle_hit = y_du
                     && ((y_w + BALL_W) == PLAT_TOP)
                     && ((x_w + BALL_W) > platx_w)
                     && (x_w < (platx_w + PLAT_W));
        fall_out   = y_du && (y_w >= Y_MAX) && !paddle_hit;

        if (x_du && (x_w >= X_MAX))
            next_x_du = 1'b0;
        else if (!x_du && (x_w == '0))
            next_x_du = 1'b1;
        else
            next_x_du = x_du ^ brick_x;

        if (!y_du && (y_w == '0))
            next_y_du = 1'b1;
        else if (paddle_hit)
            next_y_du = 1'b0;
        else if (fall_out)
            next_y_du = y_du;
        else
            next_y_du = y_du ^ brick_y;
    end

    // Controller FSM with registered outputs. enable is raised while leaving
    // STEP, so directions (updated leaving CHECK) are stable one cycle before
    // the strobe. LOST is a sticky flag parked in IDLE; only resetn clears it.
    // Brick flags are reloaded from the live pulse when leaving CHECK, which
    // clears them but keeps a pulse that lands in the CHECK cycle itself.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state     <= IDLE;
            x_du      <= 1'b1;
            y_du      <= 1'b0;
            enable    <= 1'b0;
            plat_col  <= 1'b0;
            ball_lost <= 1'b0;
            brick_x   <= 1'b0;
            brick_y   <= 1'b0;
        end else begin
            enable   <= 1'b0;
            plat_col <= 1'b0;

            case (state)
                IDLE: begin
                    if (go && !ball_lost)
                        state <= RUN;
                end
                RUN: begin
                    if (tick)
                        state <= CHECK;
                end
                CHECK: begin
                    x_du     <= next_x_du;
                    y_du     <= next_y_du;
                    plat_col <= paddle_hit;
                    if (fall_out) begin
                        ball_lost <= 1'b1;
                        state     <= IDLE;
                    end else begin
                        state <= STEP;
                    end
                end
                STEP: begin
                    enable <= 1'b1;
                    state  <= RUN;
                end
            endcase

            if (state == CHECK) begin
                brick_x <= brick_hit_x && !fall_out;
                brick_y <= brick_hit_y && !fall_out;
            end else if (state != IDLE && !ball_lost) begin
                if (brick_hit_x)
                    brick_x <= 1'b1;
                if (brick_hit_y)
                    brick_y <= 1'b1;
            end
        end
    end

endmodule
